// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display sharing one decoder.
// New values are staged in a pending register and swapped in only at frame boundaries.
module fnd_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  value_load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    output logic [3:0]            digit_nibble,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  dp_out,
    output logic                  frame_done,
    output logic                  load_ack
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_ZERO = IW'(32'd0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [IW-1:0]          idx_r;
    logic [4*DIGITS-1:0]    disp_r;
    logic [DIGITS-1:0]      dispdp_r;
    logic [4*DIGITS-1:0]    pend_r;
    logic [DIGITS-1:0]      penddp_r;
    logic                   pend_v_r;

    state_t                 state_nxt_s;
    logic                   slot_end_s;
    logic                   frame_end_s;
    logic [CW-1:0]          cnt_nxt_s;
    logic [IW-1:0]          idx_nxt_s;
    logic [4*DIGITS-1:0]    disp_nxt_s;
    logic [DIGITS-1:0]      dispdp_nxt_s;
    logic [DIGITS-1:0]      zero_above_s;
    logic                   zero_acc_s;
    logic                   suppress_s;
    logic                   lit_s;
    logic [DIGITS-1:0]      en_nxt_s;

    // Next counter, digit index, slot phase and display contents.
    always_comb begin
        slot_end_s  = (cnt_r == CNT_LAST);
        frame_end_s = slot_end_s && (idx_r == IDX_LAST);

        if (slot_end_s) begin
            cnt_nxt_s = CNT_ZERO;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = IDX_ZERO;
            end else begin
                idx_nxt_s = idx_r + IDX_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            idx_nxt_s = idx_r;
        end

        // A strobe in the frame-end cycle bypasses the pending register.
        if (frame_end_s && value_load) begin
            disp_nxt_s   = value_in;
            dispdp_nxt_s = dp_in;
        end else if (frame_end_s && pend_v_r) begin
            disp_nxt_s   = pend_r;
            dispdp_nxt_s = penddp_r;
        end else begin
            disp_nxt_s   = disp_r;
            dispdp_nxt_s = dispdp_r;
        end

        case (state_r)
            ST_BLANK: state_nxt_s = (cnt_nxt_s == CNT_SHOW) ? ST_SHOW : ST_BLANK;
            ST_SHOW:  state_nxt_s = (cnt_nxt_s == CNT_ZERO) ? ST_BLANK : ST_SHOW;
            default:  state_nxt_s = ST_BLANK;
        endcase
    end

    // Leading-zero detection and the enable pattern for the upcoming cycle.
    always_comb begin
        zero_acc_s   = 1'b1;
        zero_above_s = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc_s      = zero_acc_s && (disp_nxt_s[4*i +: 4] == 4'h0);
            zero_above_s[i] = zero_acc_s;
        end

        suppress_s = lz_blank && (idx_nxt_s != IDX_ZERO) &&
                     zero_above_s[idx_nxt_s] && !dispdp_nxt_s[idx_nxt_s];
        lit_s      = (state_nxt_s == ST_SHOW) && !suppress_s;

        en_nxt_s = {DIGITS{1'b1}};
        if (lit_s) begin
            en_nxt_s[idx_nxt_s] = 1'b0;
        end else begin
            en_nxt_s = {DIGITS{1'b1}};
        end
    end

    // Scan state, load staging and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_BLANK;
            cnt_r        <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            disp_r       <= {(4*DIGITS){1'b0}};
            dispdp_r     <= {DIGITS{1'b0}};
            pend_r       <= {(4*DIGITS){1'b0}};
            penddp_r     <= {DIGITS{1'b0}};
            pend_v_r     <= 1'b0;
            digit_nibble <= 4'h0;
            digit_en     <= {DIGITS{1'b1}};
            dp_out       <= 1'b1;
            frame_done   <= 1'b0;
            load_ack     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
            disp_r   <= disp_nxt_s;
            dispdp_r <= dispdp_nxt_s;

            if (frame_end_s) begin
                pend_v_r <= 1'b0;
            end else if (value_load) begin
                pend_r   <= value_in;
                penddp_r <= dp_in;
                pend_v_r <= 1'b1;
            end else begin
                pend_v_r <= pend_v_r;
            end

            digit_nibble <= disp_nxt_s[{idx_nxt_s, 2'b00} +: 4];
            digit_en     <= en_nxt_s;
            dp_out       <= lit_s ? ~dispdp_nxt_s[idx_nxt_s] : 1'b1;
            frame_done   <= frame_end_s;
            load_ack     <= frame_end_s && (pend_v_r || value_load);
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// pos counts cycles since reset release; a small display model supplies expected outputs.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        value_load = 1'b0;
    logic [3:0]  dp_in = 4'b0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  digit_nibble;
    logic [3:0]  digit_en;
    logic        dp_out;
    logic        frame_done;
    logic        load_ack;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pos = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [3:0]  m_dp = 4'b0000;
    logic        m_lz = 1'b0;
    logic [10:0] obs;
    logic [10:0] e;

    fnd_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .value_load(value_load),
        .dp_in(dp_in), .lz_blank(lz_blank), .digit_nibble(digit_nibble),
        .digit_en(digit_en), .dp_out(dp_out), .frame_done(frame_done),
        .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    assign obs = {digit_en, digit_nibble, dp_out, frame_done, load_ack};

    // Expected {digit_en, digit_nibble, dp_out, frame_done, load_ack} at the current pos.
    function automatic logic [10:0] exp_vec(input logic ack);
        int c, i;
        logic [3:0] nib, en;
        logic lit, dpo, fd;
        c = pos % 8;
        i = (pos / 8) % 4;
        nib = 4'((m_disp >> (4 * i)) & 16'h000F);
        lit = (c >= 2);
        if (m_lz && i > 0 && (m_disp >> (4 * i)) == 16'h0000 && !m_dp[i]) lit = 1'b0;
        en  = lit ? ~(4'b0001 << i) : 4'b1111;
        dpo = lit ? ~m_dp[i] : 1'b1;
        fd  = (pos != 0) && (pos % 32 == 0);
        return {en, nib, dpo, fd, ack};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pos = 0;
        n_checks++;
        if (digit_en !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_en got=%b exp=1111", digit_en);
        end
        n_checks++;
        if (digit_nibble !== 4'h0 || dp_out !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_nib_dp got=%h/%b exp=0/1", digit_nibble, dp_out);
        end
        n_checks++;
        if (frame_done !== 1'b0 || load_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pulses got=%b/%b exp=0/0", frame_done, load_ack);
        end
    endtask

    task automatic test_scan();
        while (pos < 32) begin
            step();
            e = exp_vec(1'b0);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL scan pos=%0d got=%b exp=%b", pos, obs, e);
            end
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_errors++;
            $display("FAIL scan_frame_done pos=%0d got=%b exp=1", pos, frame_done);
        end
    endtask

    task automatic test_load();
        while (pos < 96) begin
            if (pos == 40) begin
                value_in = 16'h1A3F; dp_in = 4'b0100; value_load = 1'b1;
            end else begin
                value_in = 16'h0000; dp_in = 4'b0000; value_load = 1'b0;
            end
            step();
            if (pos == 64) begin
                m_disp = 16'h1A3F; m_dp = 4'b0100;
            end
            e = exp_vec(pos == 64);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL load pos=%0d got=%b exp=%b", pos, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        while (pos < 160) begin
            value_load = (pos == 100) || (pos == 110);
            value_in   = (pos == 100) ? 16'h1111 : 16'h2222;
            dp_in      = 4'b0000;
            step();
            if (pos == 128) begin
                m_disp = 16'h2222; m_dp = 4'b0000;
            end
            e = exp_vec(pos == 128);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL back_to_back pos=%0d got=%b exp=%b", pos, obs, e);
            end
        end
        value_load = 1'b0;
    endtask

    task automatic test_frame_end_load();
        while (pos < 224) begin
            value_load = (pos == 191);
            value_in   = 16'h00C5;
            dp_in      = 4'b0000;
            step();
            if (pos == 192) begin
                m_disp = 16'h00C5; m_dp = 4'b0000;
            end
            e = exp_vec(pos == 192);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL frame_end_load pos=%0d got=%b exp=%b", pos, obs, e);
            end
        end
        value_load = 1'b0;
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        m_lz = 1'b1;
        while (pos < 352) begin
            value_load = (pos == 230) || (pos == 260) || (pos == 292);
            value_in   = (pos == 230) ? 16'h0070 : 16'h0000;
            dp_in      = (pos == 292) ? 4'b1000 : 4'b0000;
            step();
            if (pos == 256) begin
                m_disp = 16'h0070; m_dp = 4'b0000;
            end else if (pos == 288) begin
                m_disp = 16'h0000; m_dp = 4'b0000;
            end else if (pos == 320) begin
                m_disp = 16'h0000; m_dp = 4'b1000;
            end
            e = exp_vec((pos == 256) || (pos == 288) || (pos == 320));
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL lz_blank pos=%0d got=%b exp=%b", pos, obs, e);
            end
        end
        value_load = 1'b0;
        dp_in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        while (pos < 372) begin
            value_load = (pos == 360);
            value_in   = 16'h9999;
            dp_in      = 4'b1111;
            step();
        end
        value_load = 1'b0;
        dp_in = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        pos = 0;
        m_disp = 16'h0000;
        m_dp = 4'b0000;
        e = exp_vec(1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL reset_mid_values got=%b exp=%b", obs, e);
        end
        while (pos < 64) begin
            step();
            e = exp_vec(1'b0);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL reset_mid pos=%0d got=%b exp=%b", pos, obs, e);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_frame_end_load();
        test_lz_blank();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
